// File: rtl/window_feeder_if.sv
// Pixel-in / column-out bundle between the raster source, the window feeder and the
// downstream gradient buffer. The master drives the pixel stream and observes the bursts.
interface window_feeder_if #(
  parameter int unsigned DataBitWidth = 4,
  parameter int unsigned Channels     = 3
);
  logic [DataBitWidth*Channels-1:0] s_data;
  logic                             s_valid;
  logic                             s_sof;
  logic                             s_ready;
  logic [DataBitWidth*Channels-1:0] d_out;
  logic                             en_out;
  logic                             win_valid;
  logic                             frame_done;

  modport master (
    output s_data, s_valid, s_sof,
    input  s_ready, d_out, en_out, win_valid, frame_done
  );

  modport slave (
    input  s_data, s_valid, s_sof,
    output s_ready, d_out, en_out, win_valid, frame_done
  );
endinterface

// File: rtl/window_feeder.sv
// Window feeder: turns a raster pixel stream into 3-pixel column bursts (row-2, row-1, current)
// for a 9-deep shift register, using two line buffers that hold the previous two rows.
// Line buffer contents are never reset; rows 0 and 1 of a frame mask the stale upper taps.
module window_feeder #(
  parameter int unsigned DataBitWidth = 4,
  parameter int unsigned Channels     = 3,
  parameter int unsigned ImgWidth     = 16,
  parameter int unsigned ImgHeight    = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  window_feeder_if.slave  bus
);

  localparam int unsigned PixW = DataBitWidth * Channels;
  localparam int unsigned ColW = (ImgWidth > 1) ? $clog2(ImgWidth) : 1;
  localparam int unsigned RowW = (ImgHeight > 1) ? $clog2(ImgHeight) : 1;

  typedef enum logic [1:0] {StIdle, StEmit0, StEmit1, StEmit2} state_e;

  state_e          r_state;
  logic [ColW-1:0] r_col;
  logic [RowW-1:0] r_row;
  logic [PixW-1:0] r_cur;
  logic [PixW-1:0] r_up1;
  logic [PixW-1:0] r_d_out;
  logic            r_en_out;
  logic            r_win_valid;
  logic            r_frame_done;
  logic            r_ready;

  logic [PixW-1:0] r_lb1 [ImgWidth];
  logic [PixW-1:0] r_lb2 [ImgWidth];

  logic            w_accept;
  logic            w_last_col;
  logic            w_last_row;
  logic [ColW-1:0] w_step_col;
  logic [RowW-1:0] w_step_row;
  logic [ColW-1:0] w_new_col;
  logic [RowW-1:0] w_new_row;

  assign w_accept   = bus.s_valid & r_ready;
  assign w_last_col = (r_col == ColW'(ImgWidth - 1));
  assign w_last_row = (r_row == RowW'(ImgHeight - 1));

  // Raster position after the pixel currently held in r_col/r_row, and the position
  // that a pixel accepted this cycle takes (SOF forces the origin).
  always_comb begin
    w_step_col = r_col + ColW'(1);
    w_step_row = r_row;
    if (w_last_col) begin
      w_step_col = '0;
      w_step_row = w_last_row ? '0 : r_row + RowW'(1);
    end
    w_new_col = (r_state == StEmit2) ? w_step_col : r_col;
    w_new_row = (r_state == StEmit2) ? w_step_row : r_row;
    if (bus.s_sof) begin
      w_new_col = '0;
      w_new_row = '0;
    end
  end

  // Burst FSM with registered outputs; s_ready is low during reset and mid-burst.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= StIdle;
      r_col        <= '0;
      r_row        <= '0;
      r_cur        <= '0;
      r_up1        <= '0;
      r_d_out      <= '0;
      r_en_out     <= 1'b0;
      r_win_valid  <= 1'b0;
      r_frame_done <= 1'b0;
      r_ready      <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle, StEmit2: begin
          r_win_valid  <= 1'b0;
          r_frame_done <= 1'b0;
          if (r_state == StEmit2) begin
            r_col <= w_step_col;
            r_row <= w_step_row;
          end
          if (w_accept) begin
            r_state  <= StEmit0;
            r_ready  <= 1'b0;
            r_col    <= w_new_col;
            r_row    <= w_new_row;
            r_cur    <= bus.s_data;
            r_up1    <= r_lb1[w_new_col];
            r_d_out  <= (w_new_row >= RowW'(2)) ? r_lb2[w_new_col] : '0;
            r_en_out <= 1'b1;
          end else begin
            r_state  <= StIdle;
            r_ready  <= 1'b1;
            r_en_out <= 1'b0;
          end
        end
        StEmit0: begin
          r_state  <= StEmit1;
          r_ready  <= 1'b0;
          r_d_out  <= (r_row >= RowW'(1)) ? r_up1 : '0;
          r_en_out <= 1'b1;
        end
        StEmit1: begin
          r_state      <= StEmit2;
          r_ready      <= 1'b1;
          r_d_out      <= r_cur;
          r_en_out     <= 1'b1;
          r_win_valid  <= (r_col >= ColW'(2)) && (r_row >= RowW'(2));
          r_frame_done <= w_last_col && w_last_row;
        end
        default: begin
          r_state <= StIdle;
        end
      endcase
    end
  end

  // Line buffers shift one row down per accept: lb1 gets the new pixel, lb2 the old lb1 word.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_lb2[w_new_col] <= r_lb1[w_new_col];
      r_lb1[w_new_col] <= bus.s_data;
    end
  end

  assign bus.s_ready    = r_ready;
  assign bus.d_out      = r_d_out;
  assign bus.en_out     = r_en_out;
  assign bus.win_valid  = r_win_valid;
  assign bus.frame_done = r_frame_done;

endmodule
